// File: rtl/interp_seq_ctrl.sv
// Interpolator sequencing controller: loads ROWS rows, runs OUT_WORDS filter steps, drains FILT_LAT cycles.
// Optional build macro INTERP_SEQ_PERFCNT_EN adds a saturating per-block cycle counter output.
module interp_seq_ctrl #(
    parameter int ROWS      = 15,
    parameter int OUT_WORDS = 40,
    parameter int FILT_LAT  = 2
) (
    input  logic        clock,
    input  logic        reset_L,
    input  logic        start,
    input  logic        abort,
    input  logic        row_valid,
    output logic        row_ready,
    output logic        isr_load_L,
    output logic        filt_en,
    output logic [7:0]  filt_sel,
    output logic        of_load_L,
    output logic        busy,
    output logic        done
`ifdef INTERP_SEQ_PERFCNT_EN
    ,
    output logic [15:0] cycle_cnt
`endif
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW = $clog2(FILT_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [RW-1:0]       r_row_cnt;
    logic [7:0]          r_word_cnt;
    logic [7:0]          r_filt_sel;
    logic [DW-1:0]       r_drain_cnt;
    logic [FILT_LAT-1:0] r_dly;
    logic                r_row_ready;
    logic                r_filt_en;
    logic                r_busy;
    logic                r_done;

    logic                w_row_hs;
    logic                w_last_row;
    logic                w_last_word;
    logic                w_drain_end;
    logic                w_abort;

    assign w_row_hs    = row_valid & r_row_ready;
    assign w_last_row  = (r_row_cnt == RW'(ROWS - 1));
    assign w_last_word = (r_word_cnt == 8'(OUT_WORDS - 1));
    assign w_drain_end = (r_drain_cnt == DW'(FILT_LAT - 1));
    assign w_abort     = abort & (r_state != S_IDLE);

    // Abort wins over every state transition; it has no meaning while idle.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= S_IDLE;
            r_row_cnt   <= '0;
            r_word_cnt  <= '0;
            r_filt_sel  <= '0;
            r_drain_cnt <= '0;
            r_row_ready <= 1'b0;
            r_filt_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (w_abort) begin
            r_state     <= S_IDLE;
            r_row_ready <= 1'b0;
            r_filt_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state     <= S_FILL;
                        r_row_cnt   <= '0;
                        r_word_cnt  <= '0;
                        r_row_ready <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (w_row_hs) begin
                        r_row_cnt <= r_row_cnt + RW'(1);
                        if (w_last_row) begin
                            r_state     <= S_RUN;
                            r_row_ready <= 1'b0;
                            r_filt_en   <= 1'b1;
                            r_filt_sel  <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_word_cnt <= r_word_cnt + 8'd1;
                    if (w_last_word) begin
                        r_state     <= S_DRAIN;
                        r_filt_en   <= 1'b0;
                        r_drain_cnt <= '0;
                    end else begin
                        r_filt_sel <= r_word_cnt + 8'd1;
                    end
                end
                S_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + DW'(1);
                    if (w_drain_end) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_row_ready <= 1'b0;
                    r_filt_en   <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    // The concatenation drops its top bit, giving a plain shift for any FILT_LAT >= 1.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_dly <= '0;
        end else if (w_abort) begin
            r_dly <= '0;
        end else begin
            r_dly <= FILT_LAT'({r_dly, r_filt_en});
        end
    end

`ifdef INTERP_SEQ_PERFCNT_EN
    logic [15:0] r_cycle_cnt;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_cycle_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_cycle_cnt <= '0;
            end
        end else if (r_cycle_cnt != 16'hFFFF) begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
`endif

    assign row_ready  = r_row_ready;
    assign isr_load_L = ~w_row_hs;
    assign filt_en    = r_filt_en;
    assign filt_sel   = r_filt_sel;
    assign of_load_L  = ~r_dly[FILT_LAT-1];
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: doc/interp_seq_ctrl.md
INTERP_SEQ_CTRL -- requirements
Module: interp_seq_ctrl

Interface
REQ-001 Parameter ROWS, default 15: rows loaded into the input shift register per block.
REQ-002 Parameter OUT_WORDS, default 40: 64-bit words pushed into the output filler per block.
REQ-003 Parameter FILT_LAT, default 2: filter pipeline latency in cycles, from filt_en to result valid.
REQ-004 clock  in  1  system clock; all state changes on posedge.
REQ-005 reset_L  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin one block; sampled in IDLE only.
REQ-007 abort  in  1  terminate the current block.
REQ-008 row_valid  in  1  upstream row (120 bits) available.
REQ-009 row_ready  out  1  controller accepts a row.
REQ-010 isr_load_L  out  1  active-low load to the input shift register.
REQ-011 filt_en  out  1  filter computes one output word this cycle.
REQ-012 filt_sel  out  8  index of the word being computed, 0..OUT_WORDS-1.
REQ-013 of_load_L  out  1  active-low load to the output filler.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have the states IDLE, FILL, RUN, DRAIN and DONE, held in registered state.
REQ-017 IDLE: start=1 -> FILL on the next edge; row_cnt and word_cnt clear to 0.
REQ-018 FILL: row_ready=1; isr_load_L = ~(row_valid & row_ready), combinational; row_cnt increments on each handshake.
REQ-019 FILL: a handshake with row_cnt==ROWS-1 -> RUN; row_valid=0 stalls FILL indefinitely with no load.
REQ-020 RUN: filt_en=1 and filt_sel=word_cnt every cycle; word_cnt increments; at word_cnt==OUT_WORDS-1 -> DRAIN.
REQ-021 of_load_L SHALL be filt_en delayed FILT_LAT cycles through a registered shift line, inverted, giving exactly OUT_WORDS low cycles per block.
REQ-022 DRAIN SHALL last exactly FILT_LAT cycles, then -> DONE.
REQ-023 DONE SHALL assert done=1 for one cycle, then -> IDLE.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 abort=1 in any non-IDLE state -> IDLE on the next edge.
REQ-026 On abort, the delay line SHALL clear so no of_load_L pulse follows, and done is not asserted.
REQ-027 abort has priority over every other transition; abort in IDLE has no effect.
REQ-028 Outside FILL: row_ready=0 and isr_load_L=1. Outside RUN: filt_en=0 and filt_sel holds its last value.

Reset
REQ-029 reset_L=0 SHALL, asynchronously, force state IDLE, row_cnt=0, word_cnt=0, filt_sel=0 and the delay line to all zeros.
REQ-030 Outputs during and after reset: row_ready=0, isr_load_L=1, filt_en=0, of_load_L=1, busy=0, done=0.
REQ-031 Reset mid-block SHALL abandon the block with no further loads.

Configuration
REQ-032 With INTERP_SEQ_PERFCNT_EN defined, the block SHALL add output cycle_cnt[15:0]:
- cleared when start is accepted;
- increments each non-IDLE cycle, saturating at 16'hFFFF;
- holds its value in IDLE;
- reset value 0.
REQ-033 Without INTERP_SEQ_PERFCNT_EN, the cycle_cnt port and its logic SHALL NOT exist.

Verification
REQ-034 Default parameters, start at cycle 0, row_valid held high -> isr_load_L low for cycles 1-15, filt_en for cycles 16-55 with filt_sel 0..39, of_load_L low for cycles 18-57, done at cycle 58.
REQ-035 Same run with row_valid deasserted for 3 cycles after the 5th row -> exactly 15 isr_load_L pulses, and done moves to cycle 61.
REQ-036 abort during RUN at filt_sel=10 -> IDLE next cycle; at most 0 further of_load_L pulses; no done; busy=0.
REQ-037 start pulsed during RUN -> ignored; exactly 40 of_load_L pulses and one done.
REQ-038 reset_L low mid-FILL, asynchronously -> all outputs at reset values immediately; a new start then completes normally.
REQ-039 With INTERP_SEQ_PERFCNT_EN defined, REQ-034 scenario -> cycle_cnt=58 after done, held until the next start.
